jtag_prog_seq: RTL and testbench

Command sequencer that sits directly upstream of the memory controller. It accepts programming commands (set address, write, read, verify) over a valid/ready stream from the JTAG command decoder. For each command it runs the level-based sel/ready handshake the memory controller expects, auto-increments the address, and returns one response per command. All logic runs in the `clk` domain.

---
 rtl/jprog_pkg.sv | 26 ++
 rtl/jprog_wdog.sv | 47 ++++
 rtl/jtag_prog_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_jtag_prog_seq.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jprog_pkg.sv
// Shared definitions for the JTAG programming sequencer.
//   - jprog_op_e    : command opcodes carried on cmd_op
//   - jprog_state_e : sequencer FSM states (also exported on dbg_state)
//   - JPROG_AW/DW   : memory address / data widths
//   - JPROG_CW      : width of the per-state watchdog counter
package jprog_pkg;

  localparam int JPROG_AW = 8;
  localparam int JPROG_DW = 16;
  localparam int JPROG_CW = 16;

  typedef enum logic [1:0] {
    JPROG_SET_ADDR = 2'b00,
    JPROG_WRITE    = 2'b01,
    JPROG_READ     = 2'b10,
    JPROG_VERIFY   = 2'b11
  } jprog_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } jprog_state_e;

endpackage

// File: rtl/jprog_wdog.sv
// Per-state watchdog for the programming sequencer.
// Counts cycles spent in the current state and flags when the state's
// cycle limit has been reached.
//   clk       in  : clock
//   rst_n     in  : asynchronous active-low reset
//   restart_i in  : state is changing this cycle; count restarts at 0
//   limit_i   in  : cycle limit of the current state (0 = expires at once)
//   expired_o out : the current cycle is the limit_i-th cycle in the state
module jprog_wdog
  import jprog_pkg::*;
#(
  parameter int CW = JPROG_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart_i,
  input  logic [CW-1:0] limit_i,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q is the number of completed cycles in the state; it saturates so a
  // long stay cannot wrap back below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle in progress is number cnt_q + 1; compare one bit wider so the
  // saturated count cannot overflow.
  assign expired_o = (({1'b0, cnt_q} + (CW+1)'(1)) >= {1'b0, limit_i});

endmodule

// File: rtl/jtag_prog_seq.sv
// JTAG programming command sequencer, placed in front of the memory
// controller. Each accepted command runs (at most) one sel/ready access and
// yields exactly one response. The address auto-increments after every
// completed access.
//
// Build option: JTAG_PROG_VERIFY_EN enables the VERIFY opcode (read and
// compare). Without it opcode 11 is answered with an error response, no
// access is made, and the compare logic is not built.
//
// Ports:
//   clk, sys_rst_n         : clock, asynchronous active-low reset
//   cmd_valid/ready/op/data: command stream from the JTAG decoder
//   rsp_valid/ready/data/err: response stream back to the decoder
//   sel, we, addr, wdata   : registered request to the memory controller
//   ready, rdata           : controller idle flag and read data
//   dbg_state              : current FSM state (jprog_state_e encoding)
//
// Stream handshakes (cmd_* and rsp_*): a transfer happens on a rising clk
// edge where valid and ready are both high; the producer holds valid and the
// payload stable until that edge, and ready never depends on valid.
module jtag_prog_seq
  import jprog_pkg::*;
#(
  parameter int ACK_TIMEOUT  = 8,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [JPROG_DW-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [JPROG_DW-1:0] rsp_data,
  output logic                rsp_err,
  output logic                sel,
  output logic                we,
  output logic [JPROG_AW-1:0] addr,
  output logic [JPROG_DW-1:0] wdata,
  input  logic                ready,
  input  logic [JPROG_DW-1:0] rdata,
  output logic [1:0]          dbg_state
);

  jprog_state_e          state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [JPROG_AW-1:0]   addr_q, addr_d;
  logic [JPROG_DW-1:0]   wdata_q, wdata_d;
  logic [JPROG_DW-1:0]   rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
`ifdef JTAG_PROG_VERIFY_EN
  logic                  vfy_q, vfy_d;
  logic [JPROG_DW-1:0]   expd_q, expd_d;
`endif

  logic                  wd_restart;
  logic                  wd_expired;
  logic [JPROG_CW-1:0]   wd_limit;

  always_comb begin
    wd_limit = '0;
    case (state_q)
      ST_REQ:  wd_limit = JPROG_CW'(ACK_TIMEOUT);
      ST_WAIT: wd_limit = JPROG_CW'(DONE_TIMEOUT);
      default: wd_limit = '0;
    endcase
  end

  assign wd_restart = (state_d != state_q);

  jprog_wdog #(.CW(JPROG_CW)) u_wdog (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .restart_i (wd_restart),
    .limit_i   (wd_limit),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef JTAG_PROG_VERIFY_EN
    vfy_d      = vfy_q;
    expd_d     = expd_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (jprog_op_e'(cmd_op))
            JPROG_SET_ADDR: begin
              addr_d     = cmd_data[JPROG_AW-1:0];
              rsp_data_d = {{(JPROG_DW-JPROG_AW){1'b0}}, cmd_data[JPROG_AW-1:0]};
              rsp_err_d  = 1'b0;
              state_d    = ST_RESP;
            end
            JPROG_WRITE: begin
              we_d    = 1'b1;
              wdata_d = cmd_data;
              sel_d   = 1'b1;
              state_d = ST_REQ;
`ifdef JTAG_PROG_VERIFY_EN
              vfy_d   = 1'b0;
              expd_d  = cmd_data;
`endif
            end
            JPROG_READ: begin
              we_d    = 1'b0;
              sel_d   = 1'b1;
              state_d = ST_REQ;
`ifdef JTAG_PROG_VERIFY_EN
              vfy_d   = 1'b0;
              expd_d  = cmd_data;
`endif
            end
            JPROG_VERIFY: begin
`ifdef JTAG_PROG_VERIFY_EN
              we_d    = 1'b0;
              sel_d   = 1'b1;
              vfy_d   = 1'b1;
              expd_d  = cmd_data;
              state_d = ST_REQ;
`else
              // Illegal opcode in this build: answer with an error only.
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
              state_d    = ST_RESP;
`endif
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_REQ: begin
        if (wd_expired) begin
          sel_d      = 1'b0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (!ready) begin
          // Controller has taken the request; release sel so its edge
          // detector sees a clean low period before the next access.
          sel_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Timeout is checked first so it wins over a same-cycle completion.
        if (wd_expired) begin
          sel_d      = 1'b0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (ready) begin
          rsp_data_d = we_q ? wdata_q : rdata;
`ifdef JTAG_PROG_VERIFY_EN
          rsp_err_d  = vfy_q && (rdata != expd_q);
`else
          rsp_err_d  = 1'b0;
`endif
          addr_d     = addr_q + JPROG_AW'(1);
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef JTAG_PROG_VERIFY_EN
      vfy_q      <= 1'b0;
      expd_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef JTAG_PROG_VERIFY_EN
      vfy_q      <= vfy_d;
      expd_q     <= expd_d;
`endif
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign sel       = sel_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jtag_prog_seq.sv
// Bench for jtag_prog_seq: a memory-controller model with adjustable
// acknowledge delay / busy time, a command-level reference model feeding
// expected-access and expected-response queues, a per-cycle compare process,
// and directed scenarios with literal expectations.
module tb_jtag_prog_seq;
  import jprog_pkg::*;

  localparam int ACK_TO  = 8;
  localparam int DONE_TO = 64;
  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_VF  = 2'b11;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic        sel, we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  jtag_prog_seq #(.ACK_TIMEOUT(ACK_TO), .DONE_TIMEOUT(DONE_TO)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .dbg_state(dbg_state)
  );

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // ---------------- memory controller model ----------------
  int          ack_dly  = 3;
  int          busy_cyc = 16;
  bit          ctl_dead = 1'b0;
  bit          ctl_busy = 1'b0;
  logic [15:0] ctl_mem [256];
  logic        a_we;
  logic [7:0]  a_addr;
  logic [15:0] a_wd;

  initial begin
    ready = 1'b1;
    rdata = 16'h0000;
    for (int i = 0; i < 256; i++) ctl_mem[i] = {i[7:0], ~i[7:0]};
    forever begin
      @(negedge clk);
      if (sys_rst_n && sel) begin
        ctl_busy = 1'b1;
        a_we   = we;
        a_addr = addr;
        a_wd   = wdata;
        if (!ctl_dead) begin
          repeat (ack_dly - 1) @(negedge clk);
          ready = 1'b0;
          repeat (busy_cyc) @(negedge clk);
          if (a_we) ctl_mem[a_addr] = a_wd;
          else      rdata = ctl_mem[a_addr];
          ready = 1'b1;
        end
        for (int k = 0; k < 100 && sel; k++) @(negedge clk);
        ctl_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // exp_q entry: {data[15:0], err, addr_after[7:0]}
  // acc_q entry: {check_wdata, we, addr[7:0], wdata[15:0]}
  logic [7:0]  m_addr;
  logic [15:0] m_mem [256];
  logic [24:0] exp_q [$];
  logic [25:0] acc_q [$];

  task automatic model_cmd(input logic [1:0] op, input logic [15:0] d);
    logic        to;
    logic [15:0] v;
    // The access times out when the controller never acknowledges or stays
    // busy for the whole completion window.
    to = ctl_dead || (busy_cyc >= DONE_TO);
    case (op)
      OP_SET: begin
        m_addr = d[7:0];
        exp_q.push_back({8'h00, d[7:0], 1'b0, d[7:0]});
      end
      OP_WR: begin
        acc_q.push_back({1'b1, 1'b1, m_addr, d});
        if (to) exp_q.push_back({16'h0000, 1'b1, m_addr});
        else begin
          m_mem[m_addr] = d;
          m_addr++;
          exp_q.push_back({d, 1'b0, m_addr});
        end
      end
      OP_RD: begin
        acc_q.push_back({1'b0, 1'b0, m_addr, 16'h0000});
        if (to) exp_q.push_back({16'h0000, 1'b1, m_addr});
        else begin
          v = m_mem[m_addr];
          m_addr++;
          exp_q.push_back({v, 1'b0, m_addr});
        end
      end
      default: begin
`ifdef JTAG_PROG_VERIFY_EN
        acc_q.push_back({1'b0, 1'b0, m_addr, 16'h0000});
        if (to) exp_q.push_back({16'h0000, 1'b1, m_addr});
        else begin
          v = m_mem[m_addr];
          m_addr++;
          exp_q.push_back({v, (v != d), m_addr});
        end
`else
        exp_q.push_back({16'h0000, 1'b1, m_addr});
`endif
      end
    endcase
  endtask

  // ---------------- compare process ----------------
  logic        prev_sel = 1'b0, prev_rv = 1'b0, prev_hs = 1'b0;
  logic [15:0] prev_rd = 16'h0;
  logic        prev_re = 1'b0;
  int          sel_len = 0, last_sel_len = 0, sel_rises = 0;
  logic [15:0] last_rsp_data = 16'h0;
  logic        last_rsp_err  = 1'b0;

  always @(negedge clk) begin
    logic [24:0] e;
    logic [25:0] a;
    #2;
    if (!sys_rst_n) begin
      prev_sel = 1'b0;
      prev_rv  = 1'b0;
      prev_hs  = 1'b0;
      sel_len  = 0;
    end else begin
      if (rsp_valid || sel) check("cmd_ready_held_off", 32'(cmd_ready), 32'(0));
      if (sel && !prev_sel) begin
        sel_rises++;
        sel_len = 0;
        if (acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sel: actual=pulse at addr %0h required=no access", addr);
        end else begin
          a = acc_q.pop_front();
          check("acc_we", 32'(we), 32'(a[24]));
          check("acc_addr", 32'(addr), 32'(a[23:16]));
          if (a[25]) check("acc_wdata", 32'(wdata), 32'(a[15:0]));
        end
      end
      if (sel) sel_len++;
      if (!sel && prev_sel) last_sel_len = sel_len;
      if (rsp_valid && prev_rv && !prev_hs) begin
        check("rsp_data_stable", 32'(rsp_data), 32'(prev_rd));
        check("rsp_err_stable", 32'(rsp_err), 32'(prev_re));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: actual=data %0h required=no response", rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e[24:9]));
          check("rsp_err", 32'(rsp_err), 32'(e[8]));
          check("addr_after", 32'(addr), 32'(e[7:0]));
        end
        last_rsp_data = rsp_data;
        last_rsp_err  = rsp_err;
      end
      prev_sel = sel;
      prev_rv  = rsp_valid;
      prev_hs  = rsp_valid && rsp_ready;
      prev_rd  = rsp_data;
      prev_re  = rsp_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [15:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("cmd_accept");
    else model_cmd(op, d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ctl_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now(name);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"},       32'(sel),       32'(0));
    check({tag, "_we"},        32'(we),        32'(0));
    check({tag, "_addr"},      32'(addr),      32'(8'h00));
    check({tag, "_wdata"},     32'(wdata),     32'(16'h0000));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp_data"},  32'(rsp_data),  32'(16'h0000));
    check({tag, "_rsp_err"},   32'(rsp_err),   32'(0));
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    check({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #400000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "simulation time bound exceeded");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rises0;
    int n;
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0000;
    rsp_ready = 1'b1;
    m_addr    = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = {i[7:0], ~i[7:0]};
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // SET_ADDR: response the cycle after accept, no access.
    rises0 = sel_rises;
    send_cmd(OP_SET, 16'h0010);
    check("setaddr_rsp_next_cycle", 32'(rsp_valid), 32'(1));
    wait_done("setaddr_done");
    check("setaddr_rsp_lit", 32'(last_rsp_data), 32'(16'h0010));
    check("setaddr_addr_lit", 32'(addr), 32'(8'h10));
    check("setaddr_no_sel", 32'(sel_rises), 32'(rises0));

    // WRITE then READ with auto-increment.
    send_cmd(OP_WR, 16'hA5A5);
    check("wr_sel_next_cycle", 32'(sel), 32'(1));
    check("wr_we_lit", 32'(we), 32'(1));
    check("wr_addr_lit", 32'(addr), 32'(8'h10));
    check("wr_wdata_lit", 32'(wdata), 32'(16'hA5A5));
    wait_done("wr_done");
    check("wr_sel_len_lit", 32'(last_sel_len), 32'(3));
    send_cmd(OP_RD, 16'h0000);
    check("rd_we_lit", 32'(we), 32'(0));
    check("rd_addr_lit", 32'(addr), 32'(8'h11));
    wait_done("rd_done");
    check("rd_rsp_lit", 32'(last_rsp_data), 32'(16'h11EE));
    check("rd_addr_after_lit", 32'(addr), 32'(8'h12));

    // Address wrap at 0xFF.
    send_cmd(OP_SET, 16'h00FF);
    send_cmd(OP_WR, 16'h1234);
    check("wrap_access_addr_lit", 32'(addr), 32'(8'hFF));
    wait_done("wrap_done");
    check("wrap_addr_lit", 32'(addr), 32'(8'h00));

    // VERIFY mismatch and match at an address holding 0x1235.
    send_cmd(OP_SET, 16'h0020);
    send_cmd(OP_WR, 16'h1235);
    send_cmd(OP_SET, 16'h0020);
    wait_done("vf_prep_done");
    rises0 = sel_rises;
    send_cmd(OP_VF, 16'h1234);
    wait_done("vf_done");
`ifdef JTAG_PROG_VERIFY_EN
    check("vf_rsp_lit", 32'(last_rsp_data), 32'(16'h1235));
    check("vf_err_lit", 32'(last_rsp_err), 32'(1));
    check("vf_addr_lit", 32'(addr), 32'(8'h21));
    send_cmd(OP_SET, 16'h0020);
    send_cmd(OP_VF, 16'h1235);
    wait_done("vf_match_done");
    check("vf_match_err_lit", 32'(last_rsp_err), 32'(0));
`else
    check("vf_illegal_rsp_lit", 32'(last_rsp_data), 32'(16'h0000));
    check("vf_illegal_err_lit", 32'(last_rsp_err), 32'(1));
    check("vf_illegal_no_sel", 32'(sel_rises), 32'(rises0));
    check("vf_illegal_addr_lit", 32'(addr), 32'(8'h20));
`endif

    // Slow acknowledge just inside the REQ window.
    send_cmd(OP_SET, 16'h0040);
    ack_dly = 7;
    send_cmd(OP_RD, 16'h0000);
    wait_done("ack7_done");
    ack_dly = 3;
    check("ack7_rsp_lit", 32'(last_rsp_data), 32'(16'h40BF));
    check("ack7_sel_len_lit", 32'(last_sel_len), 32'(7));

    // Controller never acknowledges: REQ timeout after ACK_TIMEOUT cycles.
    ctl_dead = 1'b1;
    send_cmd(OP_WR, 16'hBEEF);
    wait_done("req_to_done");
    ctl_dead = 1'b0;
    check("req_to_rsp_lit", 32'(last_rsp_data), 32'(16'h0000));
    check("req_to_err_lit", 32'(last_rsp_err), 32'(1));
    check("req_to_addr_lit", 32'(addr), 32'(8'h41));
    check("req_to_sel_len_lit", 32'(last_sel_len), 32'(ACK_TO));
    check("req_to_sel_low", 32'(sel), 32'(0));
    send_cmd(OP_RD, 16'h0000);
    wait_done("after_req_to_done");
    check("after_req_to_rsp_lit", 32'(last_rsp_data), 32'(16'h41BE));

    // Controller stays busy too long: WAIT timeout.
    busy_cyc = 80;
    send_cmd(OP_RD, 16'h0000);
    wait_done("wait_to_done");
    busy_cyc = 16;
    check("wait_to_rsp_lit", 32'(last_rsp_data), 32'(16'h0000));
    check("wait_to_err_lit", 32'(last_rsp_err), 32'(1));
    check("wait_to_addr_lit", 32'(addr), 32'(8'h42));

    // Response backpressure for 10 cycles with a command held off.
    rsp_ready = 1'b0;
    send_cmd(OP_RD, 16'h0000);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) fail_now("bp_rsp_valid");
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    cmd_data  = 16'h0033;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid_held", 32'(rsp_valid), 32'(1));
      check("bp_rsp_data_lit", 32'(rsp_data), 32'(16'h42BD));
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    send_cmd(OP_SET, 16'h0033);
    wait_done("bp_done");
    check("bp_held_cmd_lit", 32'(last_rsp_data), 32'(16'h0033));

    // Reset while WAITing on the controller.
    send_cmd(OP_RD, 16'h0000);
    n = 0;
    while (dbg_state != ST_WAIT && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_wait", 32'(dbg_state), 32'(ST_WAIT));
    sys_rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    acc_q.delete();
    m_addr = 8'h00;
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    wait_done("midrst_ctl_done");

    // Back in service after reset: read from address 0.
    send_cmd(OP_RD, 16'h0000);
    wait_done("post_rst_done");
    check("post_rst_rsp_lit", 32'(last_rsp_data), 32'(16'h00FF));
    check("post_rst_addr_lit", 32'(addr), 32'(8'h01));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
